// File: rtl/clkdiv_mux.sv
// ---------------------------------------------------------------------------
// clkdiv_mux
//   NCH programmable clock dividers followed by a glitch-free selector that
//   hands one divided clock to a registered output. The selector only opens
//   or closes its gate while the relevant channel is low, so clk_out never
//   carries a runt high pulse.
//
// Optional build macro:
//   CLKDIV_SYNC_IN_EN - when defined, sel and en each pass through a 2-flop
//                       synchroniser (reset to 0) before the selector FSM.
//                       div_ratio is never synchronised.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   div_ratio  in   NCH*DIVW ratios, channel i in [i*DIVW +: DIVW]
//   sel        in   requested channel (values >= NCH are ignored)
//   en         in   output enable
//   div_clk    out  raw divided clocks, one per channel
//   clk_out    out  gated, selected clock (flop output)
//   active_sel out  channel currently driving clk_out
//   busy       out  high while a switch or enable change is in progress
// ---------------------------------------------------------------------------
module clkdiv_mux #(
  parameter int NCH  = 2,
  parameter int DIVW = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DIVW-1:0]   div_ratio,
  input  logic [SELW-1:0]       sel,
  input  logic                  en,
  output logic [NCH-1:0]        div_clk,
  output logic                  clk_out,
  output logic [SELW-1:0]       active_sel,
  output logic                  busy
);

  localparam logic [SELW:0] LP_NCH = (SELW+1)'(NCH);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Divider state
  logic [DIVW-1:0] r_cnt [NCH];
  logic [DIVW-1:0] r_shd [NCH];
  logic [NCH-1:0]  r_div_clk;
  logic [NCH-1:0]  w_div_clk_nxt;

  // Selector state
  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gate;
  logic            w_gate_nxt;
  logic [SELW-1:0] r_active_sel;
  logic [SELW-1:0] w_active_sel_nxt;
  logic            r_clk_out;

  // FSM-side view of the control inputs
  logic [SELW-1:0] w_sel;
  logic            w_en;
  logic            w_sel_ok;
  logic            w_req_clk;
  logic            w_act_clk;

`ifdef CLKDIV_SYNC_IN_EN
  logic [SELW-1:0] r_sel_s1;
  logic [SELW-1:0] r_sel_s2;
  logic            r_en_s1;
  logic            r_en_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
      r_en_s1  <= 1'b0;
      r_en_s2  <= 1'b0;
    end else begin
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
      r_en_s1  <= en;
      r_en_s2  <= r_en_s1;
    end
  end

  assign w_sel = r_sel_s2;
  assign w_en  = r_en_s2;
`else
  assign w_sel = sel;
  assign w_en  = en;
`endif

  // ---- Divider stage: next-state toggles are shared with the output flop ----
  always_comb begin
    w_div_clk_nxt = r_div_clk;
    for (int i = 0; i < NCH; i++) begin
      if (r_cnt[i] == r_shd[i]) begin
        w_div_clk_nxt[i] = ~r_div_clk[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
        r_shd[i] <= '0;
      end
      r_div_clk <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_cnt[i] == r_shd[i]) begin
          r_cnt[i] <= '0;
          // New ratio is picked up only at a toggle, so a half-period in
          // flight is never cut short.
          r_shd[i] <= div_ratio[i*DIVW +: DIVW];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_div_clk <= w_div_clk_nxt;
    end
  end

  // ---- Selector stage ----
  assign w_sel_ok  = ({1'b0, w_sel} < LP_NCH);
  // An out-of-range request reads as "high" so it can never arm.
  assign w_req_clk = w_sel_ok ? r_div_clk[w_sel] : 1'b1;
  assign w_act_clk = r_div_clk[r_active_sel];

  always_comb begin
    w_state_nxt      = r_state;
    w_gate_nxt       = r_gate;
    w_active_sel_nxt = r_active_sel;
    case (r_state)
      S_OFF: begin
        w_gate_nxt = 1'b0;
        if (w_en && w_sel_ok) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (!w_en) begin
          w_state_nxt = S_OFF;
        end else if (w_sel_ok && !w_req_clk) begin
          // Registered channel is low: opening the gate now lets the next
          // rising edge through as a full-width pulse.
          w_active_sel_nxt = w_sel;
          w_gate_nxt       = 1'b1;
          w_state_nxt      = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_en || (w_sel_ok && (w_sel != r_active_sel))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Gate stays open until the current high phase has finished.
        if (!w_act_clk) begin
          w_gate_nxt  = 1'b0;
          w_state_nxt = w_en ? S_ARM : S_OFF;
        end
      end
      default: begin
        w_gate_nxt  = 1'b0;
        w_state_nxt = S_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_gate       <= 1'b0;
      r_active_sel <= '0;
      r_clk_out    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gate       <= w_gate_nxt;
      r_active_sel <= w_active_sel_nxt;
      // Built from next-state values so clk_out lines up with div_clk.
      r_clk_out    <= w_gate_nxt & w_div_clk_nxt[w_active_sel_nxt];
    end
  end

  assign div_clk    = r_div_clk;
  assign clk_out    = r_clk_out;
  assign active_sel = r_active_sel;
  assign busy       = (r_state == S_ARM) | (r_state == S_DRAIN);

endmodule
